// File: rtl/pmem_burst_adaptor.sv
// Converts one cache-line read/write into a 4-beat burst on the physical-memory bus.
// Define WRAP_BURST_EN for critical-word-first beat ordering.
module pmem_burst_adaptor #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64,
  localparam int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned BEATS    = LINE_W / BURST_W;
  localparam int unsigned CNT_W    = $clog2(BEATS);
  localparam int unsigned OFS_LSB  = $clog2(BURST_W / 8);
  localparam int unsigned LINE_LSB = $clog2(LINE_W / 8);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_BURST = 3'd1,
    RD_DONE  = 3'd2,
    WR_BURST = 3'd3,
    WR_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   base_q, base_d;
  logic [LINE_W-1:0]  wline_q, wline_d;
  logic [LINE_W-1:0]  line_d;
  logic [BURST_W-1:0] burst_d;
  logic [ADDR_W-1:0]  addr_d;
  logic               read_d, write_d, resp_d;

  logic [ADDR_W-1:0]  req_addr_c;
  logic [CNT_W-1:0]   req_base_c;
  logic [CNT_W-1:0]   slot_c, nslot_c;
  logic               last_beat_c;
  logic               unused_addr_bits;

  // Burst address and starting slot derived from the incoming request
`ifdef WRAP_BURST_EN
  assign req_addr_c       = {address_i[ADDR_W-1:OFS_LSB], OFS_LSB'(0)};
  assign req_base_c       = address_i[LINE_LSB-1:OFS_LSB];
  assign unused_addr_bits = ^address_i[OFS_LSB-1:0];
`else
  assign req_addr_c       = {address_i[ADDR_W-1:LINE_LSB], LINE_LSB'(0)};
  assign req_base_c       = '0;
  assign unused_addr_bits = ^address_i[LINE_LSB-1:0];
`endif

  // Line slot addressed by the current beat and by the one after it
  assign slot_c      = base_q + cnt_q;
  assign nslot_c     = slot_c + CNT_W'(1);
  assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    wline_d = wline_q;
    line_d  = line_o;
    burst_d = burst_o;
    addr_d  = address_o;
    read_d  = read_o;
    write_d = write_o;
    resp_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (write_i) begin
          state_d = WR_BURST;
          addr_d  = req_addr_c;
          base_d  = req_base_c;
          wline_d = line_i;
          burst_d = line_i[BURST_W * 32'(req_base_c) +: BURST_W];
          write_d = 1'b1;
        end else if (read_i) begin
          state_d = RD_BURST;
          addr_d  = req_addr_c;
          base_d  = req_base_c;
          read_d  = 1'b1;
        end
      end

      RD_BURST: begin
        if (resp_i) begin
          line_d[BURST_W * 32'(slot_c) +: BURST_W] = burst_i;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat_c) begin
            state_d = RD_DONE;
            read_d  = 1'b0;
            resp_d  = 1'b1;
          end
        end
      end

      RD_DONE: state_d = IDLE;

      // burst_o is preloaded so the next beat is already on the bus when resp_i lands
      WR_BURST: begin
        if (resp_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          burst_d = wline_q[BURST_W * 32'(nslot_c) +: BURST_W];
          if (last_beat_c) begin
            state_d = WR_DONE;
            write_d = 1'b0;
            burst_d = '0;
            resp_d  = 1'b1;
          end
        end
      end

      WR_DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      wline_q   <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      wline_q   <= wline_d;
      line_o    <= line_d;
      burst_o   <= burst_d;
      address_o <= addr_d;
      read_o    <= read_d;
      write_o   <= write_d;
      resp_o    <= resp_d;
    end
  end

endmodule

// File: tb/tb_pmem_burst_adaptor.sv
// Scoreboard bench for pmem_burst_adaptor: random line requests against a
// slot-mapping reference model, with a randomly stalling memory responder.
module tb_pmem_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  pmem_burst_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] line;
  } txn_t;

  txn_t        exp_q[$];
  logic [63:0] wbeat_q[$];
  logic [63:0] rd_beat_q[$];
  bit          pat_q[$];
  int          resp_budget = 1000000;
  int          gap_pct = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: beat k lands in slot (start + k) mod 4
  function automatic int start_slot(input logic [31:0] a);
`ifdef WRAP_BURST_EN
    return int'(a[4:3]);
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] burst_addr(input logic [31:0] a);
`ifdef WRAP_BURST_EN
    return a & 32'hFFFF_FFF8;
`else
    return a & 32'hFFFF_FFE0;
`endif
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [255:0] l);
    txn_t t;
    logic [63:0] b;
    int s;
    @(posedge clk);
    #1;
    read_i    = rd;
    write_i   = wr;
    address_i = a;
    line_i    = l;
    s = start_slot(a);
    if (wr) begin
      t.wr = 1'b1; t.addr = burst_addr(a); t.line = l;
      exp_q.push_back(t);
      for (int k = 0; k < 4; k++) wbeat_q.push_back(l[((s + k) % 4) * 64 +: 64]);
    end
    if (rd) begin
      t.wr = 1'b0; t.addr = burst_addr(a); t.line = '0;
      for (int k = 0; k < 4; k++) begin
        b = {$urandom, $urandom};
        rd_beat_q.push_back(b);
        t.line[((s + k) % 4) * 64 +: 64] = b;
      end
      exp_q.push_back(t);
    end
  endtask

  // Waits for n completions, dropping the request lines as each is acknowledged
  task automatic wait_resp(input int n, output int lat, output int rd_cycles);
    int got = 0;
    lat = 0;
    rd_cycles = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      lat++;
      if (read_o) rd_cycles++;
      if (resp_o) begin
        got++;
        chk("req_lines_low_at_resp", 256'({read_o, write_o}), 256'(0));
        if (got == 1 && n == 2) write_i = 1'b0;
        if (got == n) begin
          read_i  = 1'b0;
          write_i = 1'b0;
          return;
        end
      end
    end
    chk("resp_timeout", 256'(got), 256'(n));
    read_i  = 1'b0;
    write_i = 1'b0;
  endtask

  // Memory responder: strobes beats while a burst is requested
  initial begin
    bit go;
    resp_i  = 1'b0;
    burst_i = '0;
    forever begin
      @(posedge clk);
      #1;
      go = 1'b0;
      if (rst && (read_o || write_o)) begin
        if (pat_q.size() > 0) go = pat_q.pop_front();
        else go = ($urandom_range(99) >= gap_pct);
      end
      if (go && resp_budget > 0) begin
        resp_budget--;
        resp_i = 1'b1;
        if (read_o) burst_i = (rd_beat_q.size() > 0) ? rd_beat_q.pop_front() : 64'(0);
        else burst_i = {$urandom, $urandom};
      end else begin
        resp_i  = 1'b0;
        burst_i = {$urandom, $urandom};
      end
    end
  end

  // Monitor: compares completions and beats against the scoreboard
  txn_t mon_t;
  bit   prev_resp = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (resp_i && (read_o || write_o)) begin
        if (exp_q.size() == 0) chk("beat_without_request", 256'(1), 256'(0));
        else begin
          chk("address_o", 256'(address_o), 256'(exp_q[0].addr));
          chk("direction", 256'({read_o, write_o}), exp_q[0].wr ? 256'(1) : 256'(2));
        end
        if (write_o) begin
          if (wbeat_q.size() == 0) chk("unexpected_write_beat", 256'(1), 256'(0));
          else chk("burst_o", 256'(burst_o), 256'(wbeat_q.pop_front()));
        end
      end
      if (resp_o) begin
        chk("resp_o_single_cycle", 256'(prev_resp), 256'(0));
        if (exp_q.size() == 0) chk("resp_without_request", 256'(1), 256'(0));
        else begin
          mon_t = exp_q.pop_front();
          if (!mon_t.wr) chk("line_o", line_o, mon_t.line);
        end
      end
      prev_resp = resp_o;
    end else begin
      prev_resp = 1'b0;
    end
  end

  initial begin
    int lat, rdc, kind;
    rst = 1'b0;
    line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_resp_o",    256'(resp_o),    256'(0));
    chk("reset_read_o",    256'(read_o),    256'(0));
    chk("reset_write_o",   256'(write_o),   256'(0));
    chk("reset_address_o", 256'(address_o), 256'(0));
    chk("reset_burst_o",   256'(burst_o),   256'(0));
    chk("reset_line_o",    line_o,          256'(0));
    rst = 1'b1;

    // Back-to-back read beats: minimum latency, read_o for 4 cycles
    gap_pct = 0;
    issue(1'b1, 1'b0, 32'h0000_1040, '0);
    wait_resp(1, lat, rdc);
    chk("read_latency", 256'(lat), 256'(6));
    chk("read_o_cycles", 256'(rdc), 256'(4));

    // Write with distinct beats
    issue(1'b0, 1'b1, 32'h8000_00E0,
          {64'hD3D3_D3D3_0000_0003, 64'hD2D2_D2D2_0000_0002,
           64'hD1D1_D1D1_0000_0001, 64'hD0D0_D0D0_0000_0000});
    wait_resp(1, lat, rdc);
    chk("write_latency", 256'(lat), 256'(6));

    // Read with gaps 1,0,0,1,1,0,1
    pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    issue(1'b1, 1'b0, 32'h0000_2000, '0);
    wait_resp(1, lat, rdc);
    chk("read_o_through_gaps", 256'(rdc), 256'(7));

    // Read and write together: write first, then read
    issue(1'b1, 1'b1, 32'h1234_5660, rand_line());
    wait_resp(2, lat, rdc);

    // Reset after 2 read beats aborts the burst
    resp_budget = 2;
    issue(1'b1, 1'b0, 32'h0000_3000, '0);
    for (int c = 0; c < 50 && resp_budget > 0; c++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_resp_o",    256'(resp_o),    256'(0));
    chk("abort_read_o",    256'(read_o),    256'(0));
    chk("abort_write_o",   256'(write_o),   256'(0));
    chk("abort_address_o", 256'(address_o), 256'(0));
    chk("abort_burst_o",   256'(burst_o),   256'(0));
    chk("abort_line_o",    line_o,          256'(0));
    read_i = 1'b0;
    exp_q.delete();
    rd_beat_q.delete();
    wbeat_q.delete();
    resp_budget = 1000000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(1'b1, 1'b0, 32'h0000_3000, '0);
    wait_resp(1, lat, rdc);
    chk("read_after_abort_latency", 256'(lat), 256'(6));

`ifdef WRAP_BURST_EN
    issue(1'b1, 1'b0, 32'h0000_1058, '0);
    wait_resp(1, lat, rdc);
    issue(1'b0, 1'b1, 32'h0000_1050, rand_line());
    wait_resp(1, lat, rdc);
`endif

    // Random mix of reads, writes and simultaneous requests with stalls
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(2);
      gap_pct = $urandom_range(60);
      issue(kind != 1, kind != 0, $urandom, rand_line());
      wait_resp((kind == 2) ? 2 : 1, lat, rdc);
      repeat ($urandom_range(3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 256'(exp_q.size() + wbeat_q.size()), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
